// File: rtl/fsm_papsel.sv
// Coin-summing vend controller, price 5: registered dispense pulse and change 1 cycle after the completing coin, no backpressure.
// Optional `credit` output (current accumulated credit) is built in when FSM_PAPSEL_CREDIT_EN is defined.
module fsm_papsel (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] m_in,
  input  logic       m_in_vld,
`ifdef FSM_PAPSEL_CREDIT_EN
  output logic [2:0] credit,
`endif
  output logic       qout,
  output logic [2:0] check
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PRICE = 4'd5;

  state_t     state_q, state_d;
  logic       qout_q,  qout_d;
  logic [2:0] check_q, check_d;
  logic [3:0] sum;

  // rstn is active-high despite its name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= S0;
      qout_q  <= 1'b0;
      check_q <= 3'd0;
    end else begin
      state_q <= state_d;
      qout_q  <= qout_d;
      check_q <= check_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qout_d  = 1'b0;
    check_d = 3'd0;
    sum     = {1'b0, state_q} + {1'b0, m_in};
    if (m_in_vld) begin
      if (sum >= PRICE) begin
        // Any excess is paid out as change now, never carried as credit.
        state_d = S0;
        qout_d  = 1'b1;
        check_d = 3'(sum - PRICE);
      end else begin
        state_d = state_t'(sum[2:0]);
      end
    end
  end

  assign qout  = qout_q;
  assign check = check_q;
`ifdef FSM_PAPSEL_CREDIT_EN
  assign credit = state_q;
`endif

endmodule

// File: tb/tb_fsm_papsel.sv
// Scoreboard bench for fsm_papsel: expectations queued at drive time, compared one cycle later.
module tb_fsm_papsel;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] m_in;
  logic       m_in_vld;
  logic       qout;
  logic [2:0] check;
`ifdef FSM_PAPSEL_CREDIT_EN
  logic [2:0] credit;
`endif

  fsm_papsel dut (
    .clk      (clk),
    .rstn     (rstn),
    .m_in     (m_in),
    .m_in_vld (m_in_vld),
`ifdef FSM_PAPSEL_CREDIT_EN
    .credit   (credit),
`endif
    .qout     (qout),
    .check    (check)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       q;
    logic [2:0] chg;
    logic [2:0] cr;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   model_cr    = 0;
  int   pulses      = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("qout",  {7'd0, qout},  {7'd0, e.q});
      chk("check", {5'd0, check}, {5'd0, e.chg});
`ifdef FSM_PAPSEL_CREDIT_EN
      chk("credit", {5'd0, credit}, {5'd0, e.cr});
`endif
      if (qout === 1'b1) pulses++;
    end
  endtask

  // One cycle: compare last cycle's result, then drive a new input and queue its expected result.
  task automatic coin(input logic vld, input logic [2:0] val);
    exp_t e;
    int   sum;
    @(negedge clk);
    observe();
    m_in_vld = vld;
    m_in     = val;
    e = '0;
    if (vld) begin
      sum = model_cr + int'(val);
      if (sum >= 5) begin
        e.q      = 1'b1;
        e.chg    = 3'(sum - 5);
        model_cr = 0;
      end else begin
        model_cr = sum;
      end
    end
    e.cr = 3'(model_cr);
    sb.push_back(e);
  endtask

  task automatic reset_pulse(input int ncyc);
    @(negedge clk);
    observe();
    rstn     = 1'b1;
    m_in_vld = 1'b0;
    m_in     = 3'd0;
    model_cr = 0;
    sb.delete();
    #1;
    chk("rst_async_qout",  {7'd0, qout},  8'd0);
    chk("rst_async_check", {5'd0, check}, 8'd0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_hold_qout", {7'd0, qout}, 8'd0);
`ifdef FSM_PAPSEL_CREDIT_EN
      chk("rst_hold_credit", {5'd0, credit}, 8'd0);
`endif
    end
    rstn = 1'b0;
  endtask

  initial begin
    rstn     = 1'b1;
    m_in_vld = 1'b0;
    m_in     = 3'd0;
    #2;
    chk("reset_qout",  {7'd0, qout},  8'd0);
    chk("reset_check", {5'd0, check}, 8'd0);
`ifdef FSM_PAPSEL_CREDIT_EN
    chk("reset_credit", {5'd0, credit}, 8'd0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b0;

    // Five single-unit coins separated by idle cycles.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      coin(1'b1, 3'd1);
      coin(1'b0, 3'd5);
    end
    coin(1'b0, 3'd0);
    chk("single_pulse_count", 8'(pulses), 8'd1);

    // Back-to-back coins with change.
    coin(1'b1, 3'd1); coin(1'b1, 3'd2); coin(1'b1, 3'd5);
    coin(1'b1, 3'd2); coin(1'b1, 3'd2); coin(1'b1, 3'd5);
    coin(1'b1, 3'd1); coin(1'b1, 3'd1); coin(1'b1, 3'd1); coin(1'b1, 3'd1); coin(1'b1, 3'd2);

    // Adjacent dispenses, then a fresh purchase.
    coin(1'b1, 3'd5); coin(1'b1, 3'd5); coin(1'b1, 3'd1); coin(1'b1, 3'd4);
    coin(1'b0, 3'd0);

    // Maximum change, then a valid zero coin.
    coin(1'b1, 3'd2); coin(1'b1, 3'd2); coin(1'b1, 3'd7);
    coin(1'b1, 3'd3); coin(1'b1, 3'd0); coin(1'b0, 3'd7);
    coin(1'b1, 3'd2);

    // Reset mid-accumulation discards partial credit.
    coin(1'b1, 3'd2); coin(1'b1, 3'd1);
    reset_pulse(2);
    coin(1'b1, 3'd2); coin(1'b1, 3'd3); coin(1'b0, 3'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      coin(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    end
    coin(1'b0, 3'd0);
    @(negedge clk);
    observe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
